threshold_segment_writer: RTL and testbench
===========================================

Name: threshold_segment_writer

Overview:
Parametrised successor to the single-window threshold cutter. It buffers a pre-trigger history of samples and, on an activity flag, writes a contiguous segment into fixed-size memory blocks: history first, then live samples, then zero padding and a trailer word. Each closed block is announced with a base-address pulse for the downstream reader. It sits between the per-sample energy/flag stage and the block RAM write port, and adds backpressure, hysteresis (hold-off), and segment continuation across blocks.

Parameters:
DATA_WIDTH, 256, sample/memory word width in bits; must be >=32.
PRE_DEPTH, 100, pre-trigger history length in samples; must be >=1.
PRE_DEPTH_INDEX, 7, ring pointer width; 2**PRE_DEPTH_INDEX >= PRE_DEPTH.
BLOCK_DEPTH, 400, words per block including the trailer; must satisfy PRE_DEPTH+2 <= BLOCK_DEPTH <= 2**BLOCK_DEPTH_INDEX.
BLOCK_DEPTH_INDEX, 9, entry index width.
BLOCK_NUM_INDEX, 4, block number width; blocks wrap modulo 2**BLOCK_NUM_INDEX.
HOLDOFF, 8, consecutive inactive samples that end a segment; must be >=1.
TAG_SEQ, 64'h0001020304050607, 8 tag bytes; the tag for a block is byte block_no[2:0], with byte 0 = bits [7:0].
DATA_BYTE_SHIFT, 5, log2 of bytes per word, used for done_addr.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  sample valid
in_ready  out  1  sample accepted when in_valid && in_ready
in_data  in  DATA_WIDTH  sample
in_flag  in  1  sample is above threshold
mem_wen  out  1  write request
mem_wready  in  1  write accepted when mem_wen && mem_wready
mem_waddr  out  BLOCK_NUM_INDEX+BLOCK_DEPTH_INDEX  {block_no, entry_idx}
mem_wdata  out  DATA_WIDTH  write data
done  out  1  one-cycle pulse: block closed
done_addr  out  32  byte base address of the closed block: {block_no, BLOCK_DEPTH_INDEX zeros} << DATA_BYTE_SHIFT, zero-extended
busy  out  1  state != IDLE

Behaviour:
- Reset values: in_ready=0, mem_wen=0, mem_waddr=0, mem_wdata=0, done=0, done_addr=0, busy=0. On reset, block_no=0, entry_idx=0, fill_cnt=0, state=IDLE.
- Reset mid-operation abandons the partial block: no trailer and no done pulse.
- Block layout: entries 0..BLOCK_DEPTH-2 hold data or padding; entry BLOCK_DEPTH-1 holds the trailer.
- Trailer format: [7:0]=tag, [23:8]=count of real (non-pad) samples in this block, [24]=cont, all higher bits 0.
- Write port: mem_wen/mem_waddr/mem_wdata are registered outputs. They are held stable while mem_wen && !mem_wready. entry_idx advances only on acceptance.
- IDLE: in_ready=1. Each accepted sample is written into the ring at ptr; ptr wraps at PRE_DEPTH-1 -> 0; fill_cnt saturates at PRE_DEPTH.
  - An accepted sample with in_flag=1 while fill_cnt==PRE_DEPTH (value before this sample) triggers. It is still written into the ring. The next state is DRAIN, with entry_idx=0 and rd_ptr = the oldest entry (ptr after the write).
  - A flagged sample while fill_cnt<PRE_DEPTH is only buffered; no trigger.
- DRAIN: in_ready=0. Emits PRE_DEPTH ring entries, oldest first, the last being the trigger sample, to entries 0..PRE_DEPTH-1. Then LIVE with quiet_cnt=0.
- LIVE: in_ready = !mem_wen || mem_wready, i.e. at most one sample in flight.
  - Each accepted sample is written to the next entry.
  - quiet_cnt increments on in_flag=0 and clears on in_flag=1.
  - The sample that makes quiet_cnt==HOLDOFF is still written; the next state is PAD.
  - If the write to entry BLOCK_DEPTH-2 is accepted first, the next state is TRAILER with cont=1. If both occur on the same sample, the full-block case wins, with cont=0.
- PAD: in_ready=0. Writes zeros until entry BLOCK_DEPTH-2 is accepted, then TRAILER (cont=0). If the hold-off sample landed in entry BLOCK_DEPTH-2, PAD is skipped.
- TRAILER: writes the trailer to entry BLOCK_DEPTH-1. On acceptance, go to DONE.
- DONE: one cycle.
  - done=1 and done_addr = base of the block just closed.
  - block_no increments (wraps); entry_idx=0.
  - If cont=1: next state is LIVE, quiet_cnt is kept, and no history is drained.
  - Else: next state is IDLE, fill_cnt=0, ptr=0 (history is rebuilt before the next trigger).
- Sample count: 16-bit saturating counter, cleared when each block starts.
- No sample is lost: input stalls whenever the write port or the state cannot accept it.

Test Plan:
- PRE_DEPTH=4, BLOCK_DEPTH=16, HOLDOFF=3, mem_wready=1. Samples 1..4 unflagged, then 5 flagged, then 6..8 unflagged -> entries 0..3 = 2,3,4,5; entries 4..6 = 6,7,8; entries 7..14 = 0; entry 15 trailer count=7, cont=0, tag=0x07; done pulse with done_addr=0.
- Flagged sample arriving as the 3rd sample after reset -> no writes; trigger occurs only after 4 samples are buffered.
- Flag held high for 30 samples after trigger -> block 0 has 15 data entries and a trailer with cont=1; block 1 continues at entry 0 with no re-drain; done_addr=0 then 16<<5=512.
- mem_wready toggling 1,0,0,1 throughout -> identical memory image to scenario 1; mem_waddr/mem_wdata stable while stalled; in_ready low during each stall.
- 17 consecutive segments -> block_no wraps 15 -> 0; tag for block 8 = 0x07.
- rst asserted mid-PAD -> no done pulse; next segment writes to block 0 at entry 0.

Source files
------------

// File: rtl/threshold_segment_writer.sv
// rtl/threshold_segment_writer.sv - pre-trigger history buffer writing flagged segments into fixed-size memory blocks
module threshold_segment_writer #(
  parameter int          DATA_WIDTH        = 256,
  parameter int          PRE_DEPTH         = 100,
  parameter int          PRE_DEPTH_INDEX   = 7,
  parameter int          BLOCK_DEPTH       = 400,
  parameter int          BLOCK_DEPTH_INDEX = 9,
  parameter int          BLOCK_NUM_INDEX   = 4,
  parameter int          HOLDOFF           = 8,
  parameter logic [63:0] TAG_SEQ           = 64'h0001020304050607,
  parameter int          DATA_BYTE_SHIFT   = 5
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [DATA_WIDTH-1:0]                      in_data,
  input  logic                                       in_flag,
  output logic                                       mem_wen,
  input  logic                                       mem_wready,
  output logic [BLOCK_NUM_INDEX+BLOCK_DEPTH_INDEX-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0]                      mem_wdata,
  output logic                                       done,
  output logic [31:0]                                done_addr,
  output logic                                       busy
);

  localparam int FW = $clog2(PRE_DEPTH + 1);
  localparam int QW = $clog2(HOLDOFF + 1);
  localparam logic [BLOCK_DEPTH_INDEX-1:0] LAST_DATA  = BLOCK_DEPTH_INDEX'(BLOCK_DEPTH - 2);
  localparam logic [BLOCK_DEPTH_INDEX-1:0] DRAIN_LAST = BLOCK_DEPTH_INDEX'(PRE_DEPTH - 1);
  localparam logic [PRE_DEPTH_INDEX-1:0]   PTR_LAST   = PRE_DEPTH_INDEX'(PRE_DEPTH - 1);
  localparam logic [FW-1:0]                FILL_FULL  = FW'(PRE_DEPTH);
  localparam logic [QW-1:0]                QUIET_END  = QW'(HOLDOFF);

  typedef enum logic [2:0] {
    S_IDLE, S_DRAIN, S_LIVE, S_PAD, S_TRAILER, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0]        ring [PRE_DEPTH];
  logic [PRE_DEPTH_INDEX-1:0]   ptr, rd_ptr, ptr_inc, rd_ptr_inc;
  logic [FW-1:0]                fill_cnt;
  logic [BLOCK_NUM_INDEX-1:0]   block_no;
  logic [BLOCK_DEPTH_INDEX-1:0] entry_idx;
  logic [QW-1:0]                quiet_cnt, quiet_nxt;
  logic [15:0]                  sample_cnt;
  logic                         cont, cont_nxt, trl_sent;
  logic                         slot_free, accept, issue, issue_real, trigger, live_take;
  logic [DATA_WIDTH-1:0]        issue_data;
  logic [2:0]                   tag_sel;
  logic [7:0]                   tag;
  logic [31:0]                  block_base;

  assign slot_free  = !mem_wen || mem_wready;
  assign accept     = in_valid && in_ready;
  assign ptr_inc    = (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
  assign rd_ptr_inc = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
  assign quiet_nxt  = in_flag ? '0 : quiet_cnt + 1'b1;
  assign tag_sel    = 3'(block_no);
  assign tag        = TAG_SEQ[{tag_sel, 3'b000} +: 8];
  assign block_base = 32'({block_no, {BLOCK_DEPTH_INDEX{1'b0}}}) << DATA_BYTE_SHIFT;
  assign busy       = (state != S_IDLE);

  // A new write is issued only when the output register is free, so every
  // state transition decided at issue time also implies the prior write landed.
  always_comb begin
    state_nxt  = state;
    cont_nxt   = cont;
    in_ready   = 1'b0;
    issue      = 1'b0;
    issue_real = 1'b0;
    issue_data = '0;
    trigger    = 1'b0;
    live_take  = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid && in_flag && fill_cnt == FILL_FULL) begin
          trigger   = 1'b1;
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (slot_free) begin
          issue      = 1'b1;
          issue_real = 1'b1;
          issue_data = ring[rd_ptr];
          if (entry_idx == DRAIN_LAST) state_nxt = S_LIVE;
        end
      end
      S_LIVE: begin
        in_ready = slot_free;
        if (in_valid && slot_free) begin
          live_take  = 1'b1;
          issue      = 1'b1;
          issue_real = 1'b1;
          issue_data = in_data;
          if (entry_idx == LAST_DATA) begin
            state_nxt = S_TRAILER;
            cont_nxt  = (quiet_nxt != QUIET_END);
          end else if (quiet_nxt == QUIET_END) begin
            state_nxt = S_PAD;
          end
        end
      end
      S_PAD: begin
        if (slot_free) begin
          issue = 1'b1;
          if (entry_idx == LAST_DATA) begin
            state_nxt = S_TRAILER;
            cont_nxt  = 1'b0;
          end
        end
      end
      S_TRAILER: begin
        if (!trl_sent) begin
          if (slot_free) begin
            issue      = 1'b1;
            issue_data = DATA_WIDTH'({cont, sample_cnt, tag});
          end
        end else if (mem_wready) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = cont ? S_LIVE : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (rst) in_ready = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (accept && state == S_IDLE) ring[ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ptr        <= '0;
      rd_ptr     <= '0;
      fill_cnt   <= '0;
      block_no   <= '0;
      entry_idx  <= '0;
      quiet_cnt  <= '0;
      sample_cnt <= '0;
      cont       <= 1'b0;
      trl_sent   <= 1'b0;
      mem_wen    <= 1'b0;
      mem_waddr  <= '0;
      mem_wdata  <= '0;
      done       <= 1'b0;
      done_addr  <= '0;
    end else begin
      state <= state_nxt;
      cont  <= cont_nxt;
      done  <= 1'b0;

      if (issue) begin
        mem_wen   <= 1'b1;
        mem_waddr <= {block_no, entry_idx};
        mem_wdata <= issue_data;
        entry_idx <= entry_idx + 1'b1;
      end else if (mem_wready) begin
        mem_wen <= 1'b0;
      end

      if (issue_real && sample_cnt != 16'hFFFF) sample_cnt <= sample_cnt + 1'b1;

      if (accept && state == S_IDLE) begin
        ptr <= ptr_inc;
        if (fill_cnt != FILL_FULL) fill_cnt <= fill_cnt + 1'b1;
      end

      // The trigger sample overwrites the oldest slot, so the oldest is now ptr+1.
      if (trigger) begin
        rd_ptr    <= ptr_inc;
        quiet_cnt <= '0;
      end

      if (state == S_DRAIN && issue) rd_ptr <= rd_ptr_inc;
      if (live_take) quiet_cnt <= quiet_nxt;
      if (state == S_TRAILER && issue) trl_sent <= 1'b1;

      if (state == S_TRAILER && trl_sent && mem_wready) begin
        done      <= 1'b1;
        done_addr <= block_base;
      end

      if (state == S_DONE) begin
        block_no   <= block_no + 1'b1;
        entry_idx  <= '0;
        sample_cnt <= '0;
        trl_sent   <= 1'b0;
        if (!cont) begin
          fill_cnt <= '0;
          ptr      <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_threshold_segment_writer.sv
// tb/tb_threshold_segment_writer.sv - self-checking bench for threshold_segment_writer
module tb_threshold_segment_writer;
  localparam int DW = 32, PD = 4, BD = 16, BDI = 4, BNI = 4, HO = 3;
  localparam logic [63:0] TAGS = 64'h0001020304050607;

  logic clk = 0, rst = 1, in_valid = 0, in_flag = 0, mem_wready = 1;
  logic [DW-1:0] in_data = 0;
  logic in_ready, mem_wen, done, busy;
  logic [BNI+BDI-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [31:0] done_addr;

  threshold_segment_writer #(
    .DATA_WIDTH(DW), .PRE_DEPTH(PD), .PRE_DEPTH_INDEX(2), .BLOCK_DEPTH(BD),
    .BLOCK_DEPTH_INDEX(BDI), .BLOCK_NUM_INDEX(BNI), .HOLDOFF(HO),
    .TAG_SEQ(TAGS), .DATA_BYTE_SHIFT(5)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_flag(in_flag), .mem_wen(mem_wen), .mem_wready(mem_wready), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .done(done), .done_addr(done_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int wmode = 0, wphase = 0;
  logic [31:0] dut_mem [256];
  bit          dut_wr  [256];
  int          dut_done_q[$];
  int          wr_count = 0;
  logic        stall_prev = 0;
  logic [7:0]  addr_prev;
  logic [31:0] data_prev;

  // reference model: segment rules applied to the accepted sample stream
  logic [31:0] hist[$];
  logic [31:0] m_data[$];
  bit          m_live;
  int          m_quiet, m_blk, m_closed;
  logic [31:0] exp_mem [256];
  bit          exp_wr  [256];
  int          exp_done[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_close(input bit c);
    for (int e = 0; e < BD - 1; e++) begin
      exp_mem[m_blk*BD + e] = (e < m_data.size()) ? m_data[e] : 32'h0;
      exp_wr[m_blk*BD + e]  = 1;
    end
    exp_mem[m_blk*BD + BD - 1] = {7'b0, c, 16'(m_data.size()), 8'(TAGS >> (8*(m_blk % 8)))};
    exp_wr[m_blk*BD + BD - 1]  = 1;
    exp_done.push_back((m_blk*BD) << 5);
    m_blk = (m_blk + 1) % 16;
    m_closed++;
    m_data.delete();
    if (!c) begin
      m_live = 0;
      hist.delete();
    end
  endtask

  task automatic model_push(input logic [31:0] d, input logic f);
    if (!m_live) begin
      bit trig = f && (hist.size() == PD);
      hist.push_back(d);
      if (hist.size() > PD) void'(hist.pop_front());
      if (trig) begin
        m_data  = hist;
        m_live  = 1;
        m_quiet = 0;
      end
    end else begin
      m_data.push_back(d);
      m_quiet = f ? 0 : m_quiet + 1;
      if (m_data.size() == BD - 1) model_close(m_quiet != HO);
      else if (m_quiet == HO) model_close(0);
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < 256; i++) begin
      dut_mem[i] = 0; dut_wr[i] = 0; exp_mem[i] = 0; exp_wr[i] = 0;
    end
    dut_done_q.delete(); exp_done.delete(); hist.delete(); m_data.delete();
    wr_count = 0; m_live = 0; m_quiet = 0; m_blk = 0; m_closed = 0;
  endtask

  always @(posedge clk) begin
    #1;
    case (wmode)
      0: mem_wready = 1;
      1: begin mem_wready = (wphase % 4 == 0) || (wphase % 4 == 3); wphase++; end
      default: mem_wready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (stall_prev) begin
        check("stall_wen", {31'b0, mem_wen}, 32'd1);
        check("stall_addr", {24'b0, mem_waddr}, {24'b0, addr_prev});
        check("stall_data", mem_wdata, data_prev);
      end
      if (mem_wen && !mem_wready) check("stall_in_ready", {31'b0, in_ready}, 32'd0);
      if (mem_wen && mem_wready) begin
        dut_mem[mem_waddr] = mem_wdata;
        dut_wr[mem_waddr]  = 1;
        wr_count++;
      end
      if (done) dut_done_q.push_back(int'(done_addr));
      stall_prev = mem_wen && !mem_wready;
      addr_prev  = mem_waddr;
      data_prev  = mem_wdata;
    end else begin
      stall_prev = 0;
    end
  end

  task automatic send(input logic [31:0] d, input logic f);
    bit acc = 0;
    in_valid = 1; in_data = d; in_flag = f;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 0;
    if (acc) model_push(d, f);
    else check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input string name);
    bit ok = 0;
    for (int n = 0; n < 3000 && !ok; n++) begin
      @(negedge clk);
      ok = !busy && !mem_wen;
    end
    check(name, {31'b0, ok}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; in_valid = 0; in_flag = 0;
    clear_all();
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic compare_model(input string name);
    for (int i = 0; i < 256; i++) begin
      check({name, "_wr"}, {31'b0, dut_wr[i]}, {31'b0, exp_wr[i]});
      if (exp_wr[i]) check({name, "_word"}, dut_mem[i], exp_mem[i]);
    end
    check({name, "_done_cnt"}, dut_done_q.size(), exp_done.size());
    for (int i = 0; i < exp_done.size() && i < dut_done_q.size(); i++)
      check({name, "_done_addr"}, dut_done_q[i], exp_done[i]);
  endtask

  typedef struct { logic [31:0] data; logic flag; } stim_t;
  typedef struct { int addr; logic [31:0] word; } img_t;
  stim_t s1[8];
  img_t  e1[16];

  task automatic run_s1(input string name);
    for (int i = 0; i < 8; i++) send(s1[i].data, s1[i].flag);
    wait_idle({name, "_idle"});
    for (int i = 0; i < 16; i++) begin
      check({name, "_written"}, {31'b0, dut_wr[e1[i].addr]}, 32'd1);
      check({name, "_entry"}, dut_mem[e1[i].addr], e1[i].word);
    end
    check({name, "_done_cnt"}, dut_done_q.size(), 32'd1);
    if (dut_done_q.size() > 0) check({name, "_done_addr"}, dut_done_q[0], 32'd0);
    compare_model(name);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) s1[i] = '{data: 32'(i + 1), flag: (i == 4)};
    for (int i = 0; i < 16; i++) begin
      e1[i].addr = i;
      if (i < 7)       e1[i].word = 32'(i + 2);
      else if (i < 15) e1[i].word = 32'h0;
      else             e1[i].word = 32'h0000_0707;
    end
    clear_all();

    @(posedge clk); @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_mem_wen", {31'b0, mem_wen}, 32'd0);
    check("rst_mem_waddr", {24'b0, mem_waddr}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_done_addr", done_addr, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);

    wmode = 0;
    do_reset();
    run_s1("s1");

    do_reset();
    send(11, 0); send(12, 0); send(13, 1);
    repeat (3) @(posedge clk);
    #1;
    check("s2_no_write", wr_count, 32'd0);
    check("s2_idle_after_early_flag", {31'b0, busy}, 32'd0);
    send(14, 1);
    repeat (2) @(posedge clk);
    #1;
    check("s2_no_trigger_at_fill3", {31'b0, busy}, 32'd0);
    send(15, 1);
    check("s2_trigger_busy", {31'b0, busy}, 32'd1);
    send(16, 0); send(17, 0); send(18, 0);
    wait_idle("s2_idle");
    check("s2_entry0", dut_mem[0], 32'd12);
    compare_model("s2");

    do_reset();
    for (int i = 1; i <= 4; i++) send(32'(100 + i), 0);
    send(105, 1);
    for (int i = 106; i <= 135; i++) send(32'(i), 1);
    for (int i = 136; i <= 138; i++) send(32'(i), 0);
    wait_idle("s3_idle");
    check("s3_blk0_trailer", dut_mem[15], 32'h0100_0F07);
    check("s3_blk1_entry0", dut_mem[16], 32'd117);
    check("s3_done_cnt", dut_done_q.size(), 32'd3);
    if (dut_done_q.size() > 1) check("s3_done1", dut_done_q[1], 32'd512);
    compare_model("s3");

    wmode = 1; wphase = 0;
    do_reset();
    run_s1("s4");

    wmode = 2;
    do_reset();
    for (int n = 0; n < 4000 && !(m_closed >= 17 && !m_live); n++)
      send($urandom, 1'($urandom_range(0, 1)));
    wait_idle("s5_idle");
    check("s5_blocks_closed", {31'b0, 1'(m_closed >= 17)}, 32'd1);
    check("s5_tag_blk8", {24'b0, dut_mem[8*BD + BD - 1][7:0]}, 32'h07);
    if (dut_done_q.size() > 16) begin
      check("s5_done8", dut_done_q[8], 32'd4096);
      check("s5_wrap_done16", dut_done_q[16], 32'd0);
    end else begin
      check("s5_done_q_len", dut_done_q.size(), 32'd17);
    end
    compare_model("s5");

    wmode = 0;
    do_reset();
    for (int i = 0; i < 8; i++) send(s1[i].data, s1[i].flag);
    begin
      bit hit = 0;
      for (int n = 0; n < 200 && !hit; n++) begin
        @(negedge clk);
        hit = mem_wen && mem_waddr[3:0] == 4'd9;
      end
      check("s6_reach_pad", {31'b0, hit}, 32'd1);
    end
    @(posedge clk); #1;
    rst = 1;
    clear_all();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (40) @(posedge clk);
    #1;
    check("s6_no_done_after_rst", dut_done_q.size(), 32'd0);
    check("s6_no_write_after_rst", wr_count, 32'd0);
    run_s1("s6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
